// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types and encodings for the write-through cache memory side
package wt_cache_pkg;

    localparam int OrigTidMaxWidth = 16;

    localparam logic SRC_ICACHE = 1'b0;
    localparam logic SRC_DCACHE = 1'b1;

    typedef struct packed {
        logic                       valid;
        logic                       src;
        logic [OrigTidMaxWidth-1:0] orig_tid;
    } wt_mem_slot_t;

endpackage

// File: rtl/wt_mem_arb_slot_alloc.sv
// wt_mem_arb_slot_alloc: transaction slot valid vector with lowest-free-index encoder
module wt_mem_arb_slot_alloc #(
    parameter int  NumTx    = 8,
    localparam int TidWidth = $clog2(NumTx)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_i,
    input  logic                rel_i,
    input  logic [TidWidth-1:0] rel_idx_i,
    output logic                free_vld_o,
    output logic [TidWidth-1:0] free_idx_o,
    output logic                any_vld_o
);

    logic [NumTx-1:0] vld_q;

    assign any_vld_o = |vld_q;

    // Lowest-index free slot; scanning downward lets the lowest index win
    always_comb begin
        free_vld_o = 1'b0;
        free_idx_o = '0;
        for (int i = NumTx - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_vld_o = 1'b1;
                free_idx_o = TidWidth'(i);
            end
        end
    end

    // Release and allocate always target different slots, so both may apply
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            if (rel_i) vld_q[rel_idx_i] <= 1'b0;
            if (alloc_i) vld_q[free_idx_o] <= 1'b1;
        end
    end

endmodule

// File: rtl/wt_mem_arb.sv
// wt_mem_arb: I$/D$ memory request arbiter with slot-based TID remapping (WT_MEM_ARB_ICACHE_PRIO_EN = fixed I$ priority)
module wt_mem_arb
    import wt_cache_pkg::*;
#(
    parameter int  NumTx        = 8,
    parameter int  ReqWidth     = 128,
    parameter int  RtrnWidth    = 256,
    parameter int  OrigTidWidth = 4,
    localparam int TidWidth     = $clog2(NumTx)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    icache_data_req_i,
    output logic                    icache_data_ack_o,
    input  logic [ReqWidth-1:0]     icache_data_i,
    input  logic [OrigTidWidth-1:0] icache_tid_i,
    input  logic                    dcache_data_req_i,
    output logic                    dcache_data_ack_o,
    input  logic [ReqWidth-1:0]     dcache_data_i,
    input  logic [OrigTidWidth-1:0] dcache_tid_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ReqWidth-1:0]     mem_req_data_o,
    output logic [TidWidth-1:0]     mem_req_tid_o,
    input  logic                    mem_rtrn_vld_i,
    input  logic [TidWidth-1:0]     mem_rtrn_tid_i,
    input  logic [RtrnWidth-1:0]    mem_rtrn_data_i,
    output logic                    icache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]    icache_rtrn_o,
    output logic [OrigTidWidth-1:0] icache_rtrn_tid_o,
    output logic                    dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]    dcache_rtrn_o,
    output logic [OrigTidWidth-1:0] dcache_rtrn_tid_o,
    output logic                    busy_o,
    output logic                    err_o
);

    logic                free_vld, any_vld, can_gnt, gnt_i, gnt_d, gnt, rtrn_hit;
    logic [TidWidth-1:0] free_idx;
    wt_mem_slot_t        tbl_q [NumTx];
    wt_mem_slot_t        rtrn_slot;

    assign can_gnt   = !rst_i && free_vld && (!mem_req_valid_o || mem_req_ready_i);
    assign gnt       = gnt_i || gnt_d;
    assign rtrn_slot = tbl_q[mem_rtrn_tid_i];
    assign rtrn_hit  = mem_rtrn_vld_i && rtrn_slot.valid;

    assign icache_data_ack_o = gnt_i;
    assign dcache_data_ack_o = gnt_d;
    assign busy_o            = any_vld || mem_req_valid_o;

`ifdef WT_MEM_ARB_ICACHE_PRIO_EN
    assign gnt_i = can_gnt && icache_data_req_i;
    assign gnt_d = can_gnt && dcache_data_req_i && !icache_data_req_i;
`else
    logic prio_d_q;
    assign gnt_i = can_gnt && icache_data_req_i && (!dcache_data_req_i || !prio_d_q);
    assign gnt_d = can_gnt && dcache_data_req_i && (!icache_data_req_i || prio_d_q);
    // Hand priority to the other requester after every grant
    always_ff @(posedge clk_i) prio_d_q <= rst_i ? 1'b0 : (gnt ? gnt_i : prio_d_q);
`endif

    wt_mem_arb_slot_alloc #(.NumTx(NumTx)) u_slot_alloc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alloc_i    (gnt),
        .rel_i      (rtrn_hit),
        .rel_idx_i  (mem_rtrn_tid_i),
        .free_vld_o (free_vld),
        .free_idx_o (free_idx),
        .any_vld_o  (any_vld)
    );

    // Slot table: record source and original TID on grant, retire on matching return
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumTx; i++) tbl_q[i] <= '0;
        end else begin
            if (rtrn_hit) tbl_q[mem_rtrn_tid_i].valid <= 1'b0;
            if (gnt) tbl_q[free_idx] <= '{valid: 1'b1, src: gnt_d ? SRC_DCACHE : SRC_ICACHE,
                orig_tid: OrigTidMaxWidth'(gnt_d ? dcache_tid_i : icache_tid_i)};
        end
    end

    // Output request register: reloads on grant, empties on handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_valid_o <= 1'b0;
            mem_req_data_o  <= '0;
            mem_req_tid_o   <= '0;
        end else if (gnt) begin
            mem_req_valid_o <= 1'b1;
            mem_req_data_o  <= gnt_d ? dcache_data_i : icache_data_i;
            mem_req_tid_o   <= free_idx;
        end else if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
        end
    end

    // Return router: steer a hit to its source cache, flag beats for idle slots
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icache_rtrn_vld_o <= 1'b0;
            icache_rtrn_o     <= '0;
            icache_rtrn_tid_o <= '0;
            dcache_rtrn_vld_o <= 1'b0;
            dcache_rtrn_o     <= '0;
            dcache_rtrn_tid_o <= '0;
            err_o             <= 1'b0;
        end else begin
            icache_rtrn_vld_o <= rtrn_hit && rtrn_slot.src == SRC_ICACHE;
            dcache_rtrn_vld_o <= rtrn_hit && rtrn_slot.src == SRC_DCACHE;
            if (rtrn_hit && rtrn_slot.src == SRC_ICACHE) begin
                icache_rtrn_o     <= mem_rtrn_data_i;
                icache_rtrn_tid_o <= OrigTidWidth'(rtrn_slot.orig_tid);
            end
            if (rtrn_hit && rtrn_slot.src == SRC_DCACHE) begin
                dcache_rtrn_o     <= mem_rtrn_data_i;
                dcache_rtrn_tid_o <= OrigTidWidth'(rtrn_slot.orig_tid);
            end
            if (mem_rtrn_vld_i && !rtrn_slot.valid) err_o <= 1'b1;
        end
    end

endmodule
